// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with centre sampling and one-cycle result strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          baud_cnt;
  logic                   baud_done;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;
`ifdef UART_RX_PARITY_EN
  logic                   parity_q;
`endif

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q      <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        START: begin
          // A start bit that is gone by its centre is treated as line noise.
          if (baud_cnt == BAUD_HALF) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            shift_q  <= {rx_s, shift_q[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            parity_q <= rx_s;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          // Leaving at the stop-bit centre lets a back-to-back start bit be caught.
          if (baud_done) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
            end else if (^{shift_q, parity_q}) begin
              parity_error <= 1'b1;
              state        <= IDLE;
              busy         <= 1'b0;
`endif
            end else begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver.
module tb_uart_receiver;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  int v0, f0, p0;

  uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .RxD(RxD),
    .data_out(data_out),
    .data_valid(data_valid),
    .framing_error(framing_error),
    .parity_error(parity_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if ($countones({data_valid === 1'b1, framing_error === 1'b1, parity_error === 1'b1}) > 1)
      overlap_cnt++;
    if (data_valid === 1'b1) begin
      valid_cnt++;
      prev_data = last_data;
      last_data = data_out;
    end
    if (framing_error === 1'b1) ferr_cnt++;
    if (parity_error === 1'b1) perr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(par);
    bit_out(stop);
  endtask
`endif

  initial begin
    logic [7:0] part;
    part = 8'hF1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_framing_error", framing_error, 1'b0);
    check("rst_parity_error", parity_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame 0xA5
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    check("a5_valid_pulses", valid_cnt - v0, 1);
    check("a5_strobe_data", last_data, 8'hA5);
    check("a5_data_out", data_out, 8'hA5);
    check("a5_busy_after", busy, 1'b0);
    check("a5_no_ferr", ferr_cnt - f0, 0);
    repeat (4) @(negedge clk);

    // Start-bit glitch of 4 cycles
    v0 = valid_cnt; f0 = ferr_cnt;
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_rise", busy, 1'b1);
    RxD = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy_fall", busy, 1'b0);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_data_out", data_out, 8'hA5);
    repeat (4) @(negedge clk);

    // Bad stop bit followed by a held-low line
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_pulses", ferr_cnt - f0, 1);
    check("ferr_no_valid", valid_cnt - v0, 0);
    check("ferr_data_out_kept", data_out, 8'hA5);
    check("ferr_busy_while_low", busy, 1'b1);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_busy_released", busy, 1'b0);
    check("ferr_no_repeat", ferr_cnt - f0, 1);
    repeat (4) @(negedge clk);

    // Back-to-back frames with no idle gap
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    check("b2b_valid_pulses", valid_cnt - v0, 2);
    check("b2b_first", prev_data, 8'h00);
    check("b2b_second", last_data, 8'hFF);
    check("b2b_no_ferr", ferr_cnt - f0, 0);
    check("b2b_data_out", data_out, 8'hFF);
    repeat (4) @(negedge clk);

    // Reset pulse in the middle of data bit 4
    v0 = valid_cnt; f0 = ferr_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(part[i]);
    RxD = part[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data_valid", data_valid, 1'b0);
    check("midrst_framing_error", framing_error, 1'b0);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 5; i < 8; i++) bit_out(part[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^part);
`endif
    bit_out(1'b1);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h81, 1'b1);
    check("after_rst_valid", valid_cnt - v0, 1);
    check("after_rst_data", data_out, 8'h81);
    repeat (4) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame_par(8'h07, 1'b1, 1'b1);
    check("par_ok_valid", valid_cnt - v0, 1);
    check("par_ok_data", data_out, 8'h07);
    check("par_ok_no_perr", perr_cnt - p0, 0);
    repeat (4) @(negedge clk);
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame_par(8'h07, 1'b0, 1'b1);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_no_valid", valid_cnt - v0, 0);
    check("par_bad_data_kept", data_out, 8'h07);
    repeat (4) @(negedge clk);
`else
    check("no_parity_strobes", perr_cnt, 0);
`endif

    check("strobes_exclusive", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
